// File: rtl/pipe_hazard_if.sv
// pipe_hazard_if: signal bundle between the pipeline datapath and its hazard control block
interface pipe_hazard_if #(
    parameter int AW = 5,
    parameter int NSTAGE = 5,
    parameter int CNT_W = 16
);
    logic [AW-1:0] id_rs, id_rt, ex_rd, mem_rd, wb_rd;
    logic ex_regwrite, ex_memread, ex_branch_taken, id_jump;
    logic mem_regwrite, mem_req, mem_ready, wb_regwrite, clr_cnt;
    logic [NSTAGE-1:0] stall, flush;
    logic [1:0] fwd_rs, fwd_rt;
    logic bus_err;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    modport master (
        output id_rs, id_rt, ex_regwrite, ex_memread, ex_rd, ex_branch_taken, id_jump,
               mem_regwrite, mem_rd, mem_req, mem_ready, wb_regwrite, wb_rd, clr_cnt,
        input  stall, flush, fwd_rs, fwd_rt, bus_err, stall_cnt, flush_cnt
    );
    modport slave (
        input  id_rs, id_rt, ex_regwrite, ex_memread, ex_rd, ex_branch_taken, id_jump,
               mem_regwrite, mem_rd, mem_req, mem_ready, wb_regwrite, wb_rd, clr_cnt,
        output stall, flush, fwd_rs, fwd_rt, bus_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/forwarding control with memory-wait timeout and hazard counters
module pipe_hazard_ctrl #(
    parameter int AW = 5,
    parameter int NSTAGE = 5,
    parameter int CNT_W = 16,
    parameter int TIMEOUT = 15
) (
    input logic clk,
    input logic reset,
    pipe_hazard_if.slave bus
);
    typedef enum logic [1:0] {RUN, MEM_WAIT, BUS_ERR} state_t;
    localparam logic [7:0] TO = 8'(TIMEOUT);
    state_t state, state_nx;
    logic [7:0] wait_cnt, wait_nx, wait_inc;
    logic mem_wait, load_use;
    logic [NSTAGE-1:0] stall, flush;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    function automatic logic [1:0] fwd_sel(input logic [AW-1:0] src, input logic ex_we,
                                           input logic [AW-1:0] ex_d, input logic mem_we,
                                           input logic [AW-1:0] mem_d, input logic wb_we,
                                           input logic [AW-1:0] wb_d);
        return src == '0              ? 2'd0 :
               ex_we && ex_d == src   ? 2'd1 :
               mem_we && mem_d == src ? 2'd2 :
               wb_we && wb_d == src   ? 2'd3 : 2'd0;
    endfunction

    assign mem_wait = state != BUS_ERR && bus.mem_req && !bus.mem_ready;
    assign load_use = bus.ex_memread && bus.ex_rd != '0 &&
                      (bus.ex_rd == bus.id_rs || bus.ex_rd == bus.id_rt);
    // wait_inc is the length of the wait including the current not-ready cycle
    assign wait_inc = wait_cnt + 8'd1;

    always_comb begin
        state_nx = RUN;
        wait_nx = '0;
        stall = '0;
        flush = '0;
        if (state == BUS_ERR) begin
            flush = {{(NSTAGE-1){1'b1}}, 1'b0};
        end else if (mem_wait) begin
            stall[3:0] = 4'hf;
            flush[4] = 1'b1;
            state_nx = wait_inc == TO ? BUS_ERR : MEM_WAIT;
            wait_nx = wait_inc == TO ? 8'd0 : wait_inc;
        end else if (bus.ex_branch_taken) begin
            flush[2:1] = 2'b11;
        end else if (load_use) begin
            stall[1:0] = 2'b11;
            flush[2] = 1'b1;
        end else if (bus.id_jump) begin
            flush[1] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
            wait_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            state <= state_nx;
            wait_cnt <= wait_nx;
            stall_cnt <= bus.clr_cnt ? '0 : stall_cnt + CNT_W'(|stall && !(&stall_cnt));
            flush_cnt <= bus.clr_cnt ? '0 : flush_cnt + CNT_W'(|flush && !(&flush_cnt));
        end
    end

    // outputs are forced quiet for the whole reset window, whatever the inputs do
    assign bus.stall = reset ? '0 : stall;
    assign bus.flush = reset ? '0 : flush;
    assign bus.bus_err = !reset && state == BUS_ERR;
    assign bus.stall_cnt = stall_cnt;
    assign bus.flush_cnt = flush_cnt;
    assign bus.fwd_rs = fwd_sel(bus.id_rs, bus.ex_regwrite, bus.ex_rd, bus.mem_regwrite,
                                bus.mem_rd, bus.wb_regwrite, bus.wb_rd);
    assign bus.fwd_rt = fwd_sel(bus.id_rt, bus.ex_regwrite, bus.ex_rd, bus.mem_regwrite,
                                bus.mem_rd, bus.wb_regwrite, bus.wb_rd);
endmodule
